seq_muldiv: RTL and testbench
=============================

SEQ_MULDIV -- requirements
Module: seq_muldiv

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width; legal values are even and >= 4.
REQ-002 SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide port start_i  input  1  request; held high by the requester until it has consumed the result.
REQ-005 SHALL provide port annul_i  input  1  cancels the operation in flight.
REQ-006 SHALL provide port op_i  input  1  0 = divide, 1 = multiply.
REQ-007 SHALL provide port signed_i  input  1  1 = two's-complement operands.
REQ-008 SHALL provide port opdata1_i  input  WIDTH  dividend or multiplicand.
REQ-009 SHALL provide port opdata2_i  input  WIDTH  divisor or multiplier.
REQ-010 SHALL provide port result_o  output  2*WIDTH  divide: {remainder, quotient}; multiply: full product.
REQ-011 SHALL provide port ready_o  output  1  result_o valid.
REQ-012 SHALL provide port busy_o  output  1  high in every state except IDLE.
REQ-013 SHALL provide port div_zero_o  output  1  divisor was zero; valid while ready_o is high.

Function
REQ-014 SHALL implement the states IDLE, DIVZERO, ON and END.
REQ-015 SHALL accept a request only in IDLE with start_i=1 and annul_i=0, latching op_i, signed_i and both operands on that edge.
REQ-016 SHALL go from IDLE to DIVZERO when op_i=0 and opdata2_i=0, and to ON otherwise.
REQ-017 SHALL in DIVZERO load result_o=0, set div_zero_o=1 and go to END; ready_o rises 2 edges after the accepting edge.
REQ-018 SHALL in ON, when signed, convert negative operands to their magnitudes, then perform one restoring-division or shift-add step per cycle for WIDTH cycles, tracked by a counter 0..WIDTH.
REQ-019 SHALL after the final step negate the quotient or product when the operand signs differ, give the remainder the dividend's sign, and go to END; ready_o rises exactly WIDTH+2 edges after the accepting edge.
REQ-020 SHALL truncate results to their field width; signed min_int / -1 yields quotient min_int and remainder 0.
REQ-021 SHALL in END hold ready_o=1 and result_o stable while start_i=1, and go to IDLE with ready_o=0 on the first edge with start_i=0.
REQ-022 SHALL when annul_i=1 in DIVZERO, ON or END go to IDLE on the next edge with ready_o=0, div_zero_o=0 and result_o=0.
REQ-023 SHALL ignore new operands while busy_o=1.

Reset
REQ-024 SHALL on rst=1 at any edge, including mid-operation, force state IDLE, counter 0, result_o=0, ready_o=0, busy_o=0 and div_zero_o=0; rst takes priority over annul_i and start_i.

Configuration
REQ-025 SHALL compile multiply support only when SEQ_MULDIV_MUL_EN is defined.
REQ-026 SHALL, when SEQ_MULDIV_MUL_EN is undefined, ignore op_i, treat every request as a divide, and contain no multiply datapath.

Structure
REQ-027 SHALL take the state encodings, the op encodings (OP_DIV=0, OP_MUL=1) and the WIDTH default from the shared package muldiv_pkg.
REQ-028 SHALL instantiate the sub-module muldiv_abs (conditional two's-complement negation, WIDTH-parametrised) for operand magnitudes and result sign correction.

Verification (WIDTH=32)
REQ-029 SHALL cover: unsigned 100 / 7 -> ready at edge 34, result_o = {0x00000002, 0x0000000E}.
REQ-030 SHALL cover: signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; and signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-031 SHALL cover: 5 / 0 -> ready at edge 2, div_zero_o = 1, result_o = 0.
REQ-032 SHALL cover: with the macro defined, signed -3 * 5 -> 0xFFFFFFFF_FFFFFFF1 at edge 34; with it undefined, op_i=1 on 15, 4 -> {0x00000003, 0x00000003}.
REQ-033 SHALL cover: annul_i pulsed on iteration 10 -> busy_o = 0 the next cycle, ready_o never rises, and a following start is accepted.
REQ-034 SHALL cover: start_i held 5 cycles past ready -> result stable; start_i dropped -> IDLE; rst on iteration 20 -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// FSM state encoding, operation encoding and the default operand width.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic OP_DIV = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negation. Used both to take operand
// magnitudes and to restore the sign of the finished result.
module muldiv_abs
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  // Negate when requested, otherwise pass through.
  always_comb begin
    dout = neg ? (~din + WIDTH'(1)) : din;
  end

endmodule

// File: rtl/seq_muldiv.sv
// Sequential multiply / divide unit.
// Divide: restoring division, one quotient bit per cycle, result {rem, quo}.
// Multiply (only when SEQ_MULDIV_MUL_EN is defined): shift-add, one
// multiplier bit per cycle, result is the full 2*WIDTH product.
// Signed operation works on magnitudes and fixes the sign at the end.
module seq_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               op_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int             CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;
  logic               div_zero_q;

  // Working registers: hi_q is the partial remainder / upper product,
  // lo_q the dividend-quotient / multiplier-lower product, b_q the
  // divisor / multiplicand magnitude.
  logic [WIDTH-1:0]   hi_q, lo_q, b_q;
  logic               neg1_q, neg2_q;

  logic               accept, step_en, fin_en;
  logic               is_mul_in;
  logic               neg1_in, neg2_in;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     rem_sh, diff;
  logic [WIDTH-1:0]   hi_step, lo_step;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] final_res;

`ifdef SEQ_MULDIV_MUL_EN
  logic               op_mul_q;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_fix;

  assign is_mul_in = (op_i == OP_MUL);
`else
  logic               unused_op;

  assign is_mul_in = 1'b0;
  assign unused_op = op_i;
`endif

  assign neg1_in = signed_i & opdata1_i[WIDTH-1];
  assign neg2_in = signed_i & opdata2_i[WIDTH-1];

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_op1 (.din(opdata1_i), .neg(neg1_in), .dout(mag1));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_op2 (.din(opdata2_i), .neg(neg2_in), .dout(mag2));

  // Quotient/product take the sign of op1 xor op2; remainder follows the dividend.
  muldiv_abs #(.WIDTH(WIDTH)) u_fix_quo (.din(lo_q), .neg(neg1_q ^ neg2_q), .dout(quo_fix));
  muldiv_abs #(.WIDTH(WIDTH)) u_fix_rem (.din(hi_q), .neg(neg1_q), .dout(rem_fix));

`ifdef SEQ_MULDIV_MUL_EN
  muldiv_abs #(.WIDTH(2*WIDTH)) u_fix_prod (.din({hi_q, lo_q}), .neg(neg1_q ^ neg2_q), .dout(prod_fix));

  assign sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign final_res = op_mul_q ? prod_fix : {rem_fix, quo_fix};
`else
  assign final_res = {rem_fix, quo_fix};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; annul aborts from any busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !annul_i) begin
          if (!is_mul_in && (opdata2_i == '0)) state_d = ST_DIVZERO;
          else                                 state_d = ST_ON;
        end
      end
      ST_DIVZERO: state_d = annul_i ? ST_IDLE : ST_END;
      ST_ON: begin
        if (annul_i)                state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST) state_d = ST_END;
      end
      ST_END: begin
        if (annul_i || !start_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and strobe decode from the current state.
  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    accept  = (state_q == ST_IDLE) && start_i && !annul_i;
    step_en = (state_q == ST_ON) && (cnt_q != CNT_LAST) && !annul_i;
    fin_en  = (state_q == ST_ON) && (cnt_q == CNT_LAST) && !annul_i;
  end

  // One restoring-division or shift-add step on the working registers.
  always_comb begin
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_q};
    if (!diff[WIDTH]) begin
      hi_step = diff[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_step = rem_sh[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], 1'b0};
    end
`ifdef SEQ_MULDIV_MUL_EN
    if (op_mul_q) begin
      hi_step = sum[WIDTH:1];
      lo_step = {sum[0], lo_q[WIDTH-1:1]};
    end
`endif
  end

  // Working registers: load magnitudes on accept, then iterate.
  always_ff @(posedge clk) begin
    if (accept) begin
      hi_q     <= '0;
      lo_q     <= mag1;
      b_q      <= mag2;
      neg1_q   <= neg1_in;
      neg2_q   <= neg2_in;
`ifdef SEQ_MULDIV_MUL_EN
      op_mul_q <= is_mul_in;
`endif
    end else if (step_en) begin
      hi_q <= hi_step;
      lo_q <= lo_step;
    end
  end

  // Control outputs: iteration counter, result, ready and divide-by-zero flag.
  always_ff @(posedge clk) begin
    if (rst || (busy_o && annul_i)) begin
      cnt_q      <= '0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
          end
        end
        ST_DIVZERO: begin
          result_q   <= '0;
          div_zero_q <= 1'b1;
        end
        ST_ON: begin
          if (step_en)     cnt_q    <= cnt_q + CNT_W'(1);
          else if (fin_en) result_q <= final_res;
        end
        ST_END:  ready_q <= start_i;
        default: ready_q <= 1'b0;
      endcase
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed bench for seq_muldiv at WIDTH=32. Edge 0 is the accepting edge.
`timescale 1ns/1ps
module tb_seq_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start_i, annul_i, op_i, signed_i;
  logic [W-1:0] opdata1_i, opdata2_i;
  logic [2*W-1:0] result_o;
  logic         ready_o, busy_o, div_zero_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
    .op_i(op_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o),
    .div_zero_o(div_zero_o)
  );

  // Issue a request and wait for ready; operands are scrambled after the
  // accepting edge so a unit that re-samples them gives a wrong answer.
  task automatic do_op(input logic op, input logic sgn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    @(negedge clk);
    op_i = op; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    annul_i = 1'b0; start_i = 1'b1;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        opdata1_i = 32'hDEAD_BEEF; opdata2_i = '0; op_i = ~op; signed_i = ~sgn;
      end
      if (ready_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; annul_i = 1'b1; op_i = 1'b0; signed_i = 1'b0;
    opdata1_i = 32'd9; opdata2_i = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_checks++; if (div_zero_o !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b expected 0", div_zero_o); end
    n_checks++; if (result_o !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result_o); end
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_div_unsigned();
    int lat;
    do_op(1'b0, 1'b0, 32'd100, 32'd7, lat);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL divu_latency: got %0d expected 34", lat); end
    n_checks++; if (result_o !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL divu_result: got %h expected 000000020000000e", result_o); end
    n_checks++; if (div_zero_o !== 1'b0) begin n_fail++; $display("FAIL divu_dz: got %b expected 0", div_zero_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL divu_busy: got %b expected 1", busy_o); end
    release_op();
  endtask

  task automatic test_div_signed();
    int lat;
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL divs_latency: got %0d expected 34", lat); end
    n_checks++; if (result_o !== 64'hFFFFFFFF_FFFFFFFD) begin n_fail++; $display("FAIL divs_m7_2: got %h expected fffffffffffffffd", result_o); end
    release_op();
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    n_checks++; if (result_o !== 64'h00000000_80000000) begin n_fail++; $display("FAIL divs_minint: got %h expected 0000000080000000", result_o); end
    release_op();
    do_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    n_checks++; if (result_o !== 64'h00000001_FFFFFFFD) begin n_fail++; $display("FAIL divs_7_m2: got %h expected 00000001fffffffd", result_o); end
    release_op();
  endtask

  task automatic test_div_zero();
    int lat;
    do_op(1'b0, 1'b0, 32'd5, 32'd0, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL dz_latency: got %0d expected 2", lat); end
    n_checks++; if (div_zero_o !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", div_zero_o); end
    n_checks++; if (result_o !== 64'h0) begin n_fail++; $display("FAIL dz_result: got %h expected 0", result_o); end
    release_op();
  endtask

  task automatic test_mul();
    int lat;
`ifdef SEQ_MULDIV_MUL_EN
    do_op(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, lat);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mul_latency: got %0d expected 34", lat); end
    n_checks++; if (result_o !== 64'hFFFFFFFF_FFFFFFF1) begin n_fail++; $display("FAIL mul_m3_5: got %h expected fffffffffffffff1", result_o); end
    n_checks++; if (div_zero_o !== 1'b0) begin n_fail++; $display("FAIL mul_dz: got %b expected 0", div_zero_o); end
    release_op();
    do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    n_checks++; if (result_o !== 64'hFFFFFFFE_00000001) begin n_fail++; $display("FAIL mul_max: got %h expected fffffffe00000001", result_o); end
    release_op();
    do_op(1'b1, 1'b0, 32'd15, 32'd4, lat);
    n_checks++; if (result_o !== 64'h00000000_0000003C) begin n_fail++; $display("FAIL mul_15_4: got %h expected 000000000000003c", result_o); end
    release_op();
`else
    do_op(1'b1, 1'b0, 32'd15, 32'd4, lat);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL nomul_latency: got %0d expected 34", lat); end
    n_checks++; if (result_o !== 64'h00000003_00000003) begin n_fail++; $display("FAIL nomul_15_4: got %h expected 0000000300000003", result_o); end
    n_checks++; if (div_zero_o !== 1'b0) begin n_fail++; $display("FAIL nomul_dz: got %b expected 0", div_zero_o); end
    release_op();
    do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    n_checks++; if (result_o !== 64'h00000000_00000001) begin n_fail++; $display("FAIL nomul_max: got %h expected 0000000000000001", result_o); end
    release_op();
    do_op(1'b1, 1'b0, 32'd9, 32'd0, lat);
    n_checks++; if (div_zero_o !== 1'b1) begin n_fail++; $display("FAIL nomul_dz0: got %b expected 1", div_zero_o); end
    release_op();
`endif
  endtask

  task automatic test_hold();
    int lat;
    do_op(1'b0, 1'b0, 32'd1000, 32'd10, lat);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL hold_latency: got %0d expected 34", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ready_o !== 1'b1 || result_o !== 64'h00000000_00000064) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got ready=%b result=%h expected ready=1 result=0000000000000064", i, ready_o, result_o);
      end
    end
    release_op();
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_drop_ready: got %b expected 0", ready_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL hold_drop_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_annul();
    int lat;
    int seen;
    @(negedge clk);
    op_i = 1'b0; signed_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5;
    annul_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL annul_busy_start: got %b expected 1", busy_o); end
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL annul_busy: got %b expected 0", busy_o); end
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL annul_ready: got %b expected 0", ready_o); end
    n_checks++; if (result_o !== 64'h0) begin n_fail++; $display("FAIL annul_result: got %h expected 0", result_o); end
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL annul_no_ready: got %0d ready cycles expected 0", seen); end
    do_op(1'b0, 1'b0, 32'd100, 32'd7, lat);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL annul_restart_lat: got %0d expected 34", lat); end
    n_checks++; if (result_o !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL annul_restart_res: got %h expected 000000020000000e", result_o); end
    release_op();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op_i = 1'b0; signed_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd0;
    annul_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; annul_i = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy_o); end
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 0", ready_o); end
    n_checks++; if (div_zero_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_dz: got %b expected 0", div_zero_o); end
    n_checks++; if (result_o !== 64'h0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 0", result_o); end
    @(negedge clk);
    rst = 1'b0; annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b expected 0", busy_o); end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 1'b0; signed_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    test_reset();
    test_div_unsigned();
    test_div_signed();
    test_div_zero();
    test_mul();
    test_hold();
    test_annul();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
